// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, state type, FSM encoding and the GF(2^8) doubling helper.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int RND_W       = 4;

  typedef logic [AES_BLOCK_W-1:0] state_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } fsm_t;

  // xtime: multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    gf_mul2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_columns.sv
// InvMixColumns: each column multiplied by the {0e,0b,0d,09} circulant matrix over GF(2^8).
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] blk,
  output logic [AES_BLOCK_W-1:0] mixed
);

  // 9, 11, 13 and 14 built from x2/x4/x8 multiples of each byte
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      m2[i] = gf_mul2(a[i]);
      m4[i] = gf_mul2(m2[i]);
      m8[i] = gf_mul2(m4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      res[31-8*i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                       ^ (m8[(i+1)%4] ^ m2[(i+1)%4] ^ a[(i+1)%4])
                       ^ (m8[(i+2)%4] ^ m4[(i+2)%4] ^ a[(i+2)%4])
                       ^ (m8[(i+3)%4] ^ a[(i+3)%4]);
    end
    inv_mix_col = res;
  endfunction

  // Four independent columns
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(blk[127-32*c -: 32]);
    end
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// InvSubBytes: 16 parallel inverse S-box lookups, purely combinational.
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] blk,
  output logic [AES_BLOCK_W-1:0] sub_blk
);

  // Entry x sits at bits [2047-8x -: 8]; that top index is simply {~x, 3'b111}.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    inv_sbox = INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  // Byte-wise lookup over the whole block
  always_comb begin
    sub_blk = '0;
    for (int i = 0; i < 16; i++) begin
      sub_blk[8*i +: 8] = inv_sbox(blk[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock over a single 128-bit state register.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [AES_BLOCK_W-1:0] i_ciphertext,
  output logic [RND_W-1:0]       o_key_round,
  input  logic [AES_BLOCK_W-1:0] i_round_key,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [AES_BLOCK_W-1:0] o_plaintext
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [RND_W-1:0] KEY_LAST  = RND_W'(NR);
  localparam logic [RND_W-1:0] RND_FIRST = RND_W'(NR - 1);

  fsm_t                   fsm_r;
  logic [RND_W-1:0]       rnd_r;
  logic [RND_W-1:0]       key_round_r;
  logic [AES_BLOCK_W-1:0] state_r;
  logic [AES_BLOCK_W-1:0] plaintext_r;
  logic                   busy_r;
  logic                   done_r;

  logic [AES_BLOCK_W-1:0] shifted_s;
  logic [AES_BLOCK_W-1:0] sub_s;
  logic [AES_BLOCK_W-1:0] addk_s;
  logic [AES_BLOCK_W-1:0] mixed_s;

  // InvShiftRows: byte (r,c) moves to column (c+r) mod 4
  always_comb begin
    shifted_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted_s[127-8*(4*((c+r)%4)+r) -: 8] = state_r[127-8*(4*c+r) -: 8];
      end
    end
  end

  inv_sub_bytes u_inv_sub_bytes (
    .blk     (shifted_s),
    .sub_blk (sub_s)
  );

  assign addk_s = sub_s ^ i_round_key;

  inv_mix_columns u_inv_mix_columns (
    .blk   (addk_s),
    .mixed (mixed_s)
  );

  // Round FSM; key index is its own register so the key store sees a clean address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= IDLE;
      rnd_r       <= RND_FIRST;
      key_round_r <= KEY_LAST;
      state_r     <= '0;
      plaintext_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if (i_start) begin
            state_r     <= i_ciphertext ^ i_round_key;
            rnd_r       <= RND_FIRST;
            key_round_r <= RND_FIRST;
            busy_r      <= 1'b1;
            fsm_r       <= ROUND;
          end
        end
        ROUND: begin
          if (rnd_r != {RND_W{1'b0}}) begin
            state_r     <= mixed_s;
            rnd_r       <= rnd_r - 4'd1;
            key_round_r <= rnd_r - 4'd1;
          end else begin
            plaintext_r <= addk_s;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            key_round_r <= KEY_LAST;
            fsm_r       <= IDLE;
          end
        end
        default: begin
          fsm_r       <= IDLE;
          busy_r      <= 1'b0;
          key_round_r <= KEY_LAST;
        end
      endcase
    end
  end

  assign o_key_round = key_round_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_plaintext = plaintext_r;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: a FIPS-197 byte-matrix model (S-box derived from GF inverse + affine)
// drives a per-cycle compare on the NR=10 instance, plus directed known-answer vectors for NR=10/14.
module tb_aes_inv_cipher_iter;

  typedef logic [127:0] blk_t;

  localparam blk_t PT    = 128'h00112233445566778899aabbccddeeff;
  localparam blk_t C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam blk_t C1_E0 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam blk_t C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam blk_t Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start10, start14;
  blk_t       ct10, ct14, rk10, rk14, pt10, pt14, junk_key;
  logic [3:0] kr10, kr14;
  logic       busy10, busy14, done10, done14, key_junk;

  blk_t       ks10 [0:14];
  blk_t       ks14 [0:14];
  blk_t       exp_rk [0:14];
  logic [7:0] sbox  [0:255];
  logic [7:0] isbox [0:255];

  int n_vec = 0;
  int n_err = 0;

  assign rk10 = key_junk ? junk_key : ks10[kr10];
  assign rk14 = ks14[kr14];

  aes_inv_cipher_iter #(.NR(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .i_start(start10), .i_ciphertext(ct10),
    .o_key_round(kr10), .i_round_key(rk10), .o_busy(busy10), .o_done(done10), .o_plaintext(pt10)
  );

  aes_inv_cipher_iter #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .i_start(start14), .i_ciphertext(ct14),
    .o_key_round(kr14), .i_round_key(rk14), .o_busy(busy14), .o_done(done14), .o_plaintext(pt14)
  );

  task automatic chk(input string nm, input blk_t act, input blk_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic blk_t rkey(input bit w14, input int i);
    return w14 ? ks14[i] : ks10[i];
  endfunction

  // FIPS-197 InvCipher on a 4x4 byte matrix
  function automatic blk_t inv_cipher(input blk_t ct, input int nr, input bit w14);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    blk_t st;
    st = ct ^ rkey(w14, nr);
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = st[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) t[r][(c+r)%4] = isbox[s[r][c]];
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) st[127-8*(4*c+r) -: 8] = t[r][c];
      st ^= rkey(w14, rnd);
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = st[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
          t[r][c] = gmul(8'h0e, s[r][c]) ^ gmul(8'h0b, s[(r+1)%4][c])
                  ^ gmul(8'h0d, s[(r+2)%4][c]) ^ gmul(8'h09, s[(r+3)%4][c]);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) st[127-8*(4*c+r) -: 8] = t[r][c];
      end
    end
    return st;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      s ^= 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h000000};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Transaction-level model of the NR=10 instance: edges left until the result appears
  int   m_left = 0;
  logic m_done = 1'b0;
  blk_t m_pt   = '0;
  blk_t m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_pt   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start10) begin
          m_left <= 10;
          m_res  <= inv_cipher(ct10, 10, 1'b0);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_pt   <= m_res;
        end
      end
    end
  end

  // Per-cycle compare of every NR=10 output against the model
  always @(negedge clk) begin
    chk("busy", blk_t'(busy10), blk_t'(m_left != 0));
    chk("done", blk_t'(done10), blk_t'(m_done));
    chk("plaintext", pt10, m_pt);
    chk("key_round", blk_t'(kr10), (m_left != 0) ? 128'(m_left - 1) : 128'd10);
  end

  task automatic start10_blk(input blk_t ct);
    start10 = 1'b1; ct10 = ct;
    @(posedge clk); #1;
    start10 = 1'b0;
  endtask

  task automatic wait_done10(output int n);
    n = 0;
    while (done10 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int   n;
  blk_t blk_b;

  initial begin
    rst_n = 1'b0; start10 = 1'b0; start14 = 1'b0; key_junk = 1'b0;
    ct10 = '0; ct14 = '0; junk_key = '0;
    build_sbox();
    expand_key(KEY_SEQ & {128'hffffffffffffffffffffffffffffffff, 128'h0}, 4, 10);
    for (int r = 0; r < 15; r++) ks10[r] = (r <= 10) ? exp_rk[r] : '0;
    expand_key(KEY_SEQ, 8, 14);
    for (int r = 0; r < 15; r++) ks14[r] = exp_rk[r];

    chk("model_c1_e0", C1_CT ^ ks10[10], C1_E0);
    chk("model_c1", inv_cipher(C1_CT, 10, 1'b0), PT);
    chk("model_c3", inv_cipher(C3_CT, 14, 1'b1), PT);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_kr14", blk_t'(kr14), 128'd14);
    chk("rst_busy14", blk_t'(busy14), 128'd0);

    // C.1 known answer
    start10_blk(C1_CT);
    wait_done10(n);
    chk("c1_latency", 128'(n), 128'd10);
    chk("c1_pt", pt10, PT);

    // Idle stability under changing inputs
    key_junk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ct10 = {$urandom, $urandom, $urandom, $urandom};
      junk_key = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    key_junk = 1'b0;
    chk("idle_pt", pt10, PT);
    chk("idle_busy", blk_t'(busy10), 128'd0);

    // Start during ROUND is ignored
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    start10_blk(C1_CT);
    repeat (4) begin @(posedge clk); #1; end
    start10_blk(blk_b);
    wait_done10(n);
    chk("ignored_latency", 128'(n), 128'd5);
    chk("ignored_pt", pt10, PT);

    // Back-to-back: start B in A's done cycle
    start10_blk(C1_CT);
    wait_done10(n);
    start10_blk(blk_b);
    chk("b2b_hold", pt10, PT);
    wait_done10(n);
    chk("b2b_latency", 128'(n), 128'd10);
    chk("b2b_pt", pt10, inv_cipher(blk_b, 10, 1'b0));

    // Asynchronous reset mid-operation
    start10_blk(C1_CT);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", blk_t'(busy10), 128'd0);
    chk("midrst_done", blk_t'(done10), 128'd0);
    chk("midrst_pt", pt10, 128'd0);
    chk("midrst_kr", blk_t'(kr10), 128'd10);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start10_blk(C1_CT);
    wait_done10(n);
    chk("postrst_latency", 128'(n), 128'd10);
    chk("postrst_pt", pt10, PT);

    // All-zero key
    expand_key(256'h0, 4, 10);
    for (int r = 0; r <= 10; r++) ks10[r] = exp_rk[r];
    chk("model_zero", inv_cipher(Z_CT, 10, 1'b0), 128'd0);
    @(posedge clk); #1;
    start10_blk(Z_CT);
    wait_done10(n);
    chk("zero_pt", pt10, 128'd0);

    // NR=14 known answer (C.3)
    start14 = 1'b1; ct14 = C3_CT;
    @(posedge clk); #1;
    start14 = 1'b0;
    chk("c3_busy", blk_t'(busy14), 128'd1);
    chk("c3_kr_first", blk_t'(kr14), 128'd13);
    n = 0;
    while (done14 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("c3_latency", 128'(n), 128'd14);
    chk("c3_pt", pt14, PT);
    chk("c3_kr_idle", blk_t'(kr14), 128'd14);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
